// File: rtl/spi_master_multi.sv
// ---------------------------------------------------------------------------
// spi_master_multi
//
// Memory-mapped SPI master shared by all SPI devices on the Hack bus.
// Supports CS_COUNT software-controlled chip selects, SPI modes 0..3,
// 8- or 16-bit frames, a programmable sck divider and sticky overrun
// detection for writes that arrive while a frame is in flight.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   load   one-cycle write strobe from the memory decoder
//   sel    register select: 0 DATA, 1 CONFIG/STATUS, 2 CS, 3 reserved
//   in     write data (CPU outM)
//   out    read data, combinational mux on sel
//   miso   serial data in
//   mosi   serial data out (idles high)
//   sck    serial clock (idles at CPOL)
//   cs     active-low chip selects, cs = ~csreg
//
// Register map:
//   write sel=1 : [0] CPHA, [1] CPOL, [2] W16, [15:8] DIV
//   read  sel=1 : {busy, ovr, 5'b0, W16, CPOL, CPHA, 6'b0}
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_master_multi #(
   parameter int CS_COUNT    = 4,
   parameter int DIV_WIDTH   = 8,
   parameter int DEFAULT_DIV = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [1:0]          sel,
   input  logic [15:0]         in,
   output logic [15:0]         out,
   input  logic                miso,
   output logic                mosi,
   output logic                sck,
   output logic [CS_COUNT-1:0] cs
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t state_reg, state_next;

   // configuration
   logic                 cpha_reg;
   logic                 cpol_reg;
   logic                 w16_reg;
   logic [DIV_WIDTH-1:0] div_reg;

   // transfer engine
   logic [DIV_WIDTH-1:0] div_cnt_reg;   // cycles left in the current half-period
   logic [4:0]           edge_cnt_reg;  // index of the next sck edge (0 .. 2N-1)
   logic [15:0]          tx_reg;        // outgoing bits, next bit at [15]
   logic [15:0]          rx_shift_reg;  // incoming bits, newest at [0]
   logic [15:0]          rx_reg;        // last completed frame
   logic                 sck_reg;
   logic                 mosi_reg;
   logic                 ovr_reg;
   logic [CS_COUNT-1:0]  cs_reg;

   // decoded control
   logic        busy;
   logic        half_done;
   logic        last_edge;
   logic        leading;
   logic        wr_idle;
   logic        start;
   logic [15:0] frame;
   logic [15:0] rx_word;

   always_comb begin
      busy      = (state_reg == SHIFT);
      // an sck edge happens on the clock where the half-period counter is spent
      half_done = busy && (div_cnt_reg == '0);
      last_edge = half_done && (edge_cnt_reg == (w16_reg ? 5'd31 : 5'd15));
      // sck always starts at CPOL, so even-numbered edges move away from it
      leading   = ~edge_cnt_reg[0];
      wr_idle   = load && !busy;
      start     = wr_idle && (sel == 2'd0);
      // 8-bit frames are left-justified so the shifter always emits from [15]
      frame     = w16_reg ? in : {in[7:0], 8'h00};
      // with CPHA=1 the final sample lands on the very edge that ends the
      // frame, so it is merged in here rather than taken from the shifter
      rx_word   = cpha_reg ? {rx_shift_reg[14:0], miso} : rx_shift_reg;
   end

   // -----------------------------------------------------------------------
   // FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)     state_next = SHIFT;
         SHIFT:   if (last_edge) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // -----------------------------------------------------------------------
   // Registers and shift engine
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpha_reg     <= 1'b0;
         cpol_reg     <= 1'b0;
         w16_reg      <= 1'b0;
         div_reg      <= DIV_WIDTH'(DEFAULT_DIV);
         div_cnt_reg  <= '0;
         edge_cnt_reg <= '0;
         tx_reg       <= '0;
         rx_shift_reg <= '0;
         rx_reg       <= '0;
         sck_reg      <= 1'b0;
         mosi_reg     <= 1'b1;
         ovr_reg      <= 1'b0;
         cs_reg       <= '0;
      end else begin
         // any access during a frame is dropped and flagged; the frame
         // itself carries on untouched
         if (load && busy) begin
            ovr_reg <= 1'b1;
         end

         if (wr_idle) begin
            case (sel)
               2'd0: begin
                  div_cnt_reg  <= div_reg;
                  edge_cnt_reg <= '0;
                  rx_shift_reg <= '0;
                  sck_reg      <= cpol_reg;
                  if (cpha_reg) begin
                     // first bit appears on the first leading edge
                     tx_reg <= frame;
                  end else begin
                     // MSB must already be on the line before the first edge
                     mosi_reg <= frame[15];
                     tx_reg   <= {frame[14:0], 1'b0};
                  end
               end
               2'd1: begin
                  cpha_reg <= in[0];
                  cpol_reg <= in[1];
                  w16_reg  <= in[2];
                  div_reg  <= in[8 +: DIV_WIDTH];
                  ovr_reg  <= 1'b0;
                  sck_reg  <= in[1];
               end
               2'd2: begin
                  cs_reg <= in[CS_COUNT-1:0];
               end
               default: ;
            endcase
         end

         if (half_done) begin
            div_cnt_reg  <= div_reg;
            edge_cnt_reg <= edge_cnt_reg + 5'd1;
            sck_reg      <= ~sck_reg;

            if (leading) begin
               if (cpha_reg) begin
                  mosi_reg <= tx_reg[15];
                  tx_reg   <= {tx_reg[14:0], 1'b0};
               end else begin
                  rx_shift_reg <= {rx_shift_reg[14:0], miso};
               end
            end else begin
               if (cpha_reg) begin
                  rx_shift_reg <= {rx_shift_reg[14:0], miso};
               end else if (!last_edge) begin
                  mosi_reg <= tx_reg[15];
                  tx_reg   <= {tx_reg[14:0], 1'b0};
               end
            end

            // the final edge is always a trailing edge: sck lands back on
            // CPOL, the line idles high and the completed word is published
            if (last_edge) begin
               sck_reg  <= cpol_reg;
               mosi_reg <= 1'b1;
               rx_reg   <= w16_reg ? rx_word : {8'h00, rx_word[7:0]};
            end
         end else if (busy) begin
            div_cnt_reg <= div_cnt_reg - DIV_WIDTH'(1);
         end
      end
   end

   // -----------------------------------------------------------------------
   // Read mux
   // -----------------------------------------------------------------------
   always_comb begin
      out = '0;
      case (sel)
         2'd0:    out = rx_reg;
         2'd1:    out = {busy, ovr_reg, 5'b00000, w16_reg, cpol_reg, cpha_reg, 6'b000000};
         2'd2:    out = 16'(cs_reg);
         default: out = '0;
      endcase
   end

   // -----------------------------------------------------------------------
   // Pins
   // -----------------------------------------------------------------------
   assign sck  = sck_reg;
   assign mosi = mosi_reg;

   for (genvar gi = 0; gi < CS_COUNT; gi++) begin : g_cs
      assign cs[gi] = ~cs_reg[gi];
   end

endmodule
